// File: rtl/retire_controller.sv
// Gates up to two in-order ROB retirements per cycle into RF write ports and sequences
// branch-mispredict recovery (flush, fetch redirect, dispatch stall) with a small FSM.
module retire_controller #(
  parameter int RECOVER_CYCLES = 2,
  parameter int COUNT_BITS     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rob_inst1_retire_tag_in,
  input  logic [4:0]            rob_inst1_dest_in,
  input  logic [63:0]           rob_inst1_value_in,
  input  logic                  rob_inst1_mispredicted_in,
  input  logic [63:0]           rob_inst1_NPC_in,
  input  logic [7:0]            rob_inst2_retire_tag_in,
  input  logic [4:0]            rob_inst2_dest_in,
  input  logic [63:0]           rob_inst2_value_in,
  input  logic                  rob_inst2_mispredicted_in,
  input  logic [63:0]           rob_inst2_NPC_in,
  input  logic                  rob_empty_in,
  output logic                  rf_wr1_en_out,
  output logic [4:0]            rf_wr1_idx_out,
  output logic [63:0]           rf_wr1_data_out,
  output logic                  rf_wr2_en_out,
  output logic [4:0]            rf_wr2_idx_out,
  output logic [63:0]           rf_wr2_data_out,
  output logic                  flush_out,
  output logic                  redirect_valid_out,
  output logic [63:0]           redirect_pc_out,
  output logic                  dispatch_stall_out,
  output logic [1:0]            state_out,
  output logic [COUNT_BITS-1:0] retired_count_out,
  output logic [15:0]           mispredict_count_out
);

  localparam int CntW = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RECOVER_CYCLES);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StFlush   = 2'b01,
    StRecover = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q;
  logic [63:0]             redirect_pc_q;
  logic [COUNT_BITS-1:0]   retired_q;
  logic [15:0]             mis_cnt_q;

  logic in_run, v1, v2, commit1, commit2, mis, recover_done;

  assign in_run  = (state_q == StRun);
  assign v1      = (rob_inst1_retire_tag_in != 8'hFF);
  // Slot 2 is only meaningful behind a valid slot 1.
  assign v2      = v1 && (rob_inst2_retire_tag_in != 8'hFF);
  assign commit1 = in_run && v1;
  assign commit2 = in_run && v2 && !rob_inst1_mispredicted_in;
  assign mis     = (commit1 && rob_inst1_mispredicted_in) ||
                   (commit2 && rob_inst2_mispredicted_in);
  assign recover_done = (int'(cnt_q) >= RECOVER_CYCLES - 1) && rob_empty_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (mis) state_d = StFlush;
      StFlush:   state_d = (RECOVER_CYCLES > 0) ? StRecover : StRun;
      StRecover: if (recover_done) state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    flush_out          = (state_q == StFlush);
    redirect_valid_out = (state_q == StFlush);
    dispatch_stall_out = (state_q != StRun);
    state_out          = state_q;
    rf_wr2_en_out      = commit2 && (rob_inst2_dest_in != 5'd0);
    // Same destination in both slots: the younger write wins.
    rf_wr1_en_out      = commit1 && (rob_inst1_dest_in != 5'd0) &&
                         !(rf_wr2_en_out && (rob_inst1_dest_in == rob_inst2_dest_in));
    rf_wr1_idx_out     = rob_inst1_dest_in;
    rf_wr1_data_out    = rob_inst1_value_in;
    rf_wr2_idx_out     = rob_inst2_dest_in;
    rf_wr2_data_out    = rob_inst2_value_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      redirect_pc_q <= '0;
      retired_q     <= '0;
      mis_cnt_q     <= '0;
    end else begin
      if (mis) begin
        redirect_pc_q <= (commit1 && rob_inst1_mispredicted_in) ? rob_inst1_NPC_in
                                                                : rob_inst2_NPC_in;
        mis_cnt_q     <= mis_cnt_q + 16'd1;
      end
      retired_q <= retired_q + COUNT_BITS'(commit1) + COUNT_BITS'(commit2);
      if (state_q == StFlush) begin
        cnt_q <= '0;
      end else if (state_q == StRecover && cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign redirect_pc_out      = redirect_pc_q;
  assign retired_count_out    = retired_q;
  assign mispredict_count_out = mis_cnt_q;

endmodule

// File: tb/tb_retire_controller.sv
// Directed bench for retire_controller: table of single-cycle retire vectors plus
// hand-written mispredict / recovery / reset-during-flush sequences.
module tb_retire_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  tag1, tag2;
  logic [4:0]  dest1, dest2;
  logic [63:0] val1, val2, npc1, npc2;
  logic        mis1, mis2, rob_empty;
  logic        wr1_en, wr2_en, flush, redir, stall;
  logic [4:0]  wr1_idx, wr2_idx;
  logic [63:0] wr1_data, wr2_data, redir_pc;
  logic [1:0]  state;
  logic [31:0] ret_cnt;
  logic [15:0] mis_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  always #5 clock = ~clock;

  retire_controller #(.RECOVER_CYCLES(2), .COUNT_BITS(32)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .rob_inst1_retire_tag_in   (tag1),
    .rob_inst1_dest_in         (dest1),
    .rob_inst1_value_in        (val1),
    .rob_inst1_mispredicted_in (mis1),
    .rob_inst1_NPC_in          (npc1),
    .rob_inst2_retire_tag_in   (tag2),
    .rob_inst2_dest_in         (dest2),
    .rob_inst2_value_in        (val2),
    .rob_inst2_mispredicted_in (mis2),
    .rob_inst2_NPC_in          (npc2),
    .rob_empty_in              (rob_empty),
    .rf_wr1_en_out             (wr1_en),
    .rf_wr1_idx_out            (wr1_idx),
    .rf_wr1_data_out           (wr1_data),
    .rf_wr2_en_out             (wr2_en),
    .rf_wr2_idx_out            (wr2_idx),
    .rf_wr2_data_out           (wr2_data),
    .flush_out                 (flush),
    .redirect_valid_out        (redir),
    .redirect_pc_out           (redir_pc),
    .dispatch_stall_out        (stall),
    .state_out                 (state),
    .retired_count_out         (ret_cnt),
    .mispredict_count_out      (mis_cnt)
  );

  typedef struct {
    logic [7:0]  t1;
    logic [4:0]  d1;
    logic [63:0] v1;
    logic [7:0]  t2;
    logic [4:0]  d2;
    logic [63:0] v2;
    logic        e1;
    logic        e2;
    int          dc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    tag1 = 8'hFF; dest1 = '0; val1 = '0; mis1 = 1'b0; npc1 = '0;
    tag2 = 8'hFF; dest2 = '0; val2 = '0; mis2 = 1'b0; npc2 = '0;
  endtask

  initial begin
    vecs[0] = '{8'd3,  5'd5,  64'hAA, 8'd4,  5'd6,  64'hBB, 1'b1, 1'b1, 2};
    vecs[1] = '{8'd10, 5'd12, 64'h11, 8'd11, 5'd12, 64'h22, 1'b0, 1'b1, 2};
    vecs[2] = '{8'hFF, 5'd7,  64'h33, 8'd2,  5'd7,  64'h44, 1'b0, 1'b0, 0};
    vecs[3] = '{8'd1,  5'd0,  64'h55, 8'd2,  5'd8,  64'h66, 1'b0, 1'b1, 2};
    vecs[4] = '{8'd5,  5'd9,  64'h77, 8'hFF, 5'd3,  64'h88, 1'b1, 1'b0, 1};
    vecs[5] = '{8'd5,  5'd0,  64'h99, 8'd6,  5'd0,  64'hCC, 1'b0, 1'b0, 2};

    idle();
    rob_empty = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_redir", 64'(redir), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_pc", redir_pc, 64'd0);
    chk("rst_ret", 64'(ret_cnt), 64'd0);
    chk("rst_mis", 64'(mis_cnt), 64'd0);
    chk("rst_wr1", 64'(wr1_en), 64'd0);

    for (int i = 0; i < 6; i++) begin
      tag1 = vecs[i].t1; dest1 = vecs[i].d1; val1 = vecs[i].v1;
      tag2 = vecs[i].t2; dest2 = vecs[i].d2; val2 = vecs[i].v2;
      #1;
      chk($sformatf("v%0d_wr1_en", i), 64'(wr1_en), 64'(vecs[i].e1));
      chk($sformatf("v%0d_wr2_en", i), 64'(wr2_en), 64'(vecs[i].e2));
      if (vecs[i].e1) chk($sformatf("v%0d_wr1_idx", i), 64'(wr1_idx), 64'(vecs[i].d1));
      if (vecs[i].e1) chk($sformatf("v%0d_wr1_data", i), wr1_data, vecs[i].v1);
      if (vecs[i].e2) chk($sformatf("v%0d_wr2_idx", i), 64'(wr2_idx), 64'(vecs[i].d2));
      if (vecs[i].e2) chk($sformatf("v%0d_wr2_data", i), wr2_data, vecs[i].v2);
      step();
      exp_ret += vecs[i].dc;
      chk($sformatf("v%0d_ret", i), 64'(ret_cnt), 64'(exp_ret));
    end
    idle();

    // Slot-1 mispredict; younger slot squashed; slow ROB drain during RECOVER.
    tag1 = 8'd7; dest1 = 5'd10; val1 = 64'h70; mis1 = 1'b1; npc1 = 64'h100;
    tag2 = 8'd8; dest2 = 5'd9;  val2 = 64'h80;
    rob_empty = 1'b0;
    #1;
    chk("m1_wr1_en", 64'(wr1_en), 64'd1);
    chk("m1_wr2_en", 64'(wr2_en), 64'd0);
    step();
    exp_ret += 1;
    chk("m1_state", 64'(state), 64'd1);
    chk("m1_flush", 64'(flush), 64'd1);
    chk("m1_redir", 64'(redir), 64'd1);
    chk("m1_stall", 64'(stall), 64'd1);
    chk("m1_pc", redir_pc, 64'h100);
    chk("m1_mis", 64'(mis_cnt), 64'd1);
    chk("m1_ret", 64'(ret_cnt), 64'(exp_ret));
    idle();
    tag1 = 8'd9; dest1 = 5'd4; val1 = 64'h90;
    #1;
    chk("m1_flush_wr1", 64'(wr1_en), 64'd0);
    step();
    chk("m1_rec_state", 64'(state), 64'd2);
    chk("m1_rec_flush", 64'(flush), 64'd0);
    chk("m1_rec_redir", 64'(redir), 64'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("m1_rec%0d_wr1", c), 64'(wr1_en), 64'd0);
      chk($sformatf("m1_rec%0d_stall", c), 64'(stall), 64'd1);
      step();
      chk($sformatf("m1_rec%0d_state", c), 64'(state), 64'd2);
    end
    rob_empty = 1'b1;
    #1;
    chk("m1_rec_last_wr1", 64'(wr1_en), 64'd0);
    step();
    chk("m1_run_state", 64'(state), 64'd0);
    chk("m1_run_stall", 64'(stall), 64'd0);
    chk("m1_run_ret", 64'(ret_cnt), 64'(exp_ret));
    chk("m1_run_wr1", 64'(wr1_en), 64'd1);
    step();
    exp_ret += 1;
    idle();

    // Slot-2 mispredict, ROB already empty: RECOVER lasts exactly two cycles.
    tag1 = 8'd1; dest1 = 5'd2; val1 = 64'h12;
    tag2 = 8'd2; dest2 = 5'd3; val2 = 64'h23; mis2 = 1'b1; npc2 = 64'h200;
    #1;
    chk("m2_wr1_en", 64'(wr1_en), 64'd1);
    chk("m2_wr2_en", 64'(wr2_en), 64'd1);
    step();
    exp_ret += 2;
    chk("m2_state", 64'(state), 64'd1);
    chk("m2_pc", redir_pc, 64'h200);
    chk("m2_mis", 64'(mis_cnt), 64'd2);
    chk("m2_ret", 64'(ret_cnt), 64'(exp_ret));
    idle();
    step();
    chk("m2_rec_a", 64'(state), 64'd2);
    step();
    chk("m2_rec_b", 64'(state), 64'd2);
    step();
    chk("m2_run", 64'(state), 64'd0);

    // Both slots mispredicted: oldest NPC wins, then reset lands during FLUSH.
    tag1 = 8'd1; dest1 = 5'd2; mis1 = 1'b1; npc1 = 64'h300;
    tag2 = 8'd2; dest2 = 5'd5; mis2 = 1'b1; npc2 = 64'h400;
    #1;
    chk("m3_wr2_en", 64'(wr2_en), 64'd0);
    step();
    exp_ret += 1;
    chk("m3_state", 64'(state), 64'd1);
    chk("m3_pc", redir_pc, 64'h300);
    chk("m3_mis", 64'(mis_cnt), 64'd3);
    chk("m3_ret", 64'(ret_cnt), 64'(exp_ret));
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("m3_rst_state", 64'(state), 64'd0);
    chk("m3_rst_flush", 64'(flush), 64'd0);
    chk("m3_rst_redir", 64'(redir), 64'd0);
    chk("m3_rst_stall", 64'(stall), 64'd0);
    chk("m3_rst_ret", 64'(ret_cnt), 64'd0);
    chk("m3_rst_mis", 64'(mis_cnt), 64'd0);
    step();
    chk("m3_post_state", 64'(state), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
